instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: owns the fetch PC, drives imem reads, queues returned words
module instr_fetch #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dq_valid,
  input  logic        dq_ready,
  output logic [31:0] dq_instr,
  output logic [31:0] dq_pc,
  output logic [31:0] dq_pc_next
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, count_nxt;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic          enq, deq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  always_comb begin
    enq        = (state_q == REQ) && imem_resp && !redirect;
    deq        = dq_valid && dq_ready && !redirect;
    count_nxt  = count_q + CW'(enq) - CW'(deq);
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    wr_ptr_d   = wr_ptr_q + PW'(enq);
    rd_ptr_d   = rd_ptr_q + PW'(deq);
    count_d    = count_nxt;
    if (redirect) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      // A response arriving with the redirect retires the old request, so
      // the new address can go out at once even from DISCARD.
      if (state_q != IDLE && !imem_resp) begin
        state_d = DISCARD;
      end else begin
        state_d = REQ;
        addr_d  = redirect_pc;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q < FULL) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end
        end
        REQ: begin
          if (imem_resp) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (count_nxt < FULL) begin
              state_d = REQ;
              addr_d  = fetch_pc_q + 32'd4;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DISCARD: begin
          if (imem_resp) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_rmask = (state_q == IDLE) ? 4'h0 : 4'hF;
    imem_addr  = addr_q;
    dq_valid   = (count_q != '0);
    dq_instr   = instr_mem[rd_ptr_q];
    dq_pc      = pc_mem[rd_ptr_q];
    dq_pc_next = pc_mem[rd_ptr_q] + 32'd4;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - bench for instr_fetch: directed table, fill/drain, random vs queue model
module tb_instr_fetch;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dq_valid;
  logic        dq_ready = 1'b0;
  logic [31:0] dq_instr, dq_pc, dq_pc_next;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dq_valid(dq_valid), .dq_ready(dq_ready),
    .dq_instr(dq_instr), .dq_pc(dq_pc), .dq_pc_next(dq_pc_next)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: instruction queue plus "one request outstanding, maybe stale".
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_addr;
  bit          m_out, m_stale;

  task automatic model_reset();
    mq.delete();
    m_pc    = RPC;
    m_addr  = RPC;
    m_out   = 1'b0;
    m_stale = 1'b0;
  endtask

  task automatic model_step();
    int old_sz = mq.size();
    bit take   = (old_sz != 0) && dq_ready;
    if (redirect) begin
      mq.delete();
      m_pc = redirect_pc;
      if (m_out && !imem_resp) begin
        m_stale = 1'b1;
      end else begin
        m_out   = 1'b1;
        m_stale = 1'b0;
        m_addr  = redirect_pc;
      end
    end else begin
      if (take) void'(mq.pop_front());
      if (m_out && imem_resp) begin
        if (!m_stale) begin
          mq.push_back('{instr: imem_rdata, pc: m_pc});
          m_pc = m_pc + 32'd4;
        end
        m_out   = 1'b0;
        m_stale = 1'b0;
        if (mq.size() < DEPTH) begin
          m_out  = 1'b1;
          m_addr = m_pc;
        end
      end else if (!m_out && old_sz < DEPTH) begin
        m_out  = 1'b1;
        m_addr = m_pc;
      end
    end
  endtask

  task automatic check_model();
    chk("model_rmask", 32'(imem_rmask), m_out ? 32'hF : 32'h0);
    if (m_out) chk("model_addr", imem_addr, m_addr);
    chk("model_valid", 32'(dq_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("model_instr", dq_instr, mq[0].instr);
      chk("model_pc", dq_pc, mq[0].pc);
      chk("model_pc_next", dq_pc_next, mq[0].pc + 32'd4);
    end
  endtask

  task automatic tick();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  int mem_wait = 0;
  int mem_lat  = 0;
  task automatic drive_mem(input int maxlat);
    if (imem_rmask == 4'hF && mem_wait >= mem_lat) begin
      imem_resp  = 1'b1;
      imem_rdata = $urandom;
      mem_wait   = 0;
      mem_lat    = $urandom_range(0, maxlat);
    end else begin
      imem_resp = 1'b0;
      if (imem_rmask == 4'hF) mem_wait++;
    end
  endtask

  typedef struct {
    bit          redir;
    logic [31:0] rpc;
    bit          resp;
    logic [31:0] rdata;
    bit          ready;
    logic [3:0]  e_rmask;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(bit rd, logic [31:0] rp, bit rs, logic [31:0] dat, bit rdy,
                              logic [3:0] em, logic [31:0] ea, bit ev, logic [31:0] ep,
                              logic [31:0] ei);
    vec_t v;
    v.redir = rd; v.rpc = rp; v.resp = rs; v.rdata = dat; v.ready = rdy;
    v.e_rmask = em; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  initial begin
    vec_t tbl[15];
    int   k;
    // Row n: inputs applied before the edge, outputs expected after it.
    tbl[0]  = mk(0, 0,            0, 0,            1, 4'hF, 32'h1eceb000, 0, 0,            0);
    tbl[1]  = mk(0, 0,            1, 32'hA0000000, 1, 4'hF, 32'h1eceb004, 1, 32'h1eceb000, 32'hA0000000);
    tbl[2]  = mk(0, 0,            1, 32'hA0000001, 1, 4'hF, 32'h1eceb008, 1, 32'h1eceb004, 32'hA0000001);
    tbl[3]  = mk(0, 0,            1, 32'hA0000002, 1, 4'hF, 32'h1eceb00c, 1, 32'h1eceb008, 32'hA0000002);
    tbl[4]  = mk(1, 32'h1eceb100, 0, 0,            0, 4'hF, 32'h1eceb00c, 0, 0,            0);
    tbl[5]  = mk(1, 32'h1eceb200, 0, 0,            0, 4'hF, 32'h1eceb00c, 0, 0,            0);
    tbl[6]  = mk(0, 0,            1, 32'hDEAD0000, 0, 4'hF, 32'h1eceb200, 0, 0,            0);
    tbl[7]  = mk(0, 0,            1, 32'hA0000003, 0, 4'hF, 32'h1eceb204, 1, 32'h1eceb200, 32'hA0000003);
    tbl[8]  = mk(1, 32'h1eceb100, 1, 32'hDEAD0001, 0, 4'hF, 32'h1eceb100, 0, 0,            0);
    tbl[9]  = mk(0, 0,            1, 32'hA0000005, 1, 4'hF, 32'h1eceb104, 1, 32'h1eceb100, 32'hA0000005);
    tbl[10] = mk(0, 0,            0, 0,            1, 4'hF, 32'h1eceb104, 0, 0,            0);
    tbl[11] = mk(1, 32'h1eceb100, 0, 0,            1, 4'hF, 32'h1eceb104, 0, 0,            0);
    tbl[12] = mk(0, 0,            0, 0,            1, 4'hF, 32'h1eceb104, 0, 0,            0);
    tbl[13] = mk(0, 0,            1, 32'hDEAD0002, 1, 4'hF, 32'h1eceb100, 0, 0,            0);
    tbl[14] = mk(0, 0,            0, 0,            1, 4'hF, 32'h1eceb100, 0, 0,            0);

    rst = 1'b1;
    tick();
    tick();
    chk("reset_rmask", 32'(imem_rmask), 32'h0);
    chk("reset_addr", imem_addr, RPC);
    chk("reset_valid", 32'(dq_valid), 32'h0);

    rst = 1'b0;
    foreach (tbl[i]) begin
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      imem_resp   = tbl[i].resp;
      imem_rdata  = tbl[i].rdata;
      dq_ready    = tbl[i].ready;
      tick();
      chk($sformatf("tbl%0d_rmask", i), 32'(imem_rmask), 32'(tbl[i].e_rmask));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(dq_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), dq_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_instr", i), dq_instr, tbl[i].e_instr);
        chk($sformatf("tbl%0d_pc_next", i), dq_pc_next, tbl[i].e_pc + 32'd4);
      end
    end
    redirect  = 1'b0;
    imem_resp = 1'b0;

    // Fill with decode stalled, then drain through several pointer wraps.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    dq_ready = 1'b0;
    mem_wait = 0;
    mem_lat  = 0;
    for (int c = 0; c < 14; c++) begin
      drive_mem(0);
      tick();
    end
    chk("full_rmask", 32'(imem_rmask), 32'h0);
    chk("full_head_pc", dq_pc, RPC);
    chk("full_entries", 32'(mq.size()), 32'(DEPTH));
    k = 0;
    dq_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (dq_valid) begin
        chk("drain_pc", dq_pc, RPC + 32'(4 * k));
        k++;
      end
      drive_mem(0);
      tick();
    end
    chk("drain_count_ge_20", 32'(k >= 20), 32'h1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = RPC + (32'($urandom_range(0, 255)) << 2);
      dq_ready    = ($urandom_range(0, 2) != 0);
      drive_mem(3);
      tick();
    end
    redirect = 1'b0;

    // Reset with a partly filled queue and a request outstanding.
    rst = 1'b1;
    imem_resp = 1'b0;
    tick();
    rst      = 1'b0;
    dq_ready = 1'b0;
    mem_wait = 0;
    mem_lat  = 0;
    for (int c = 0; c < 5; c++) begin
      drive_mem(0);
      tick();
    end
    chk("pre_rst_valid", 32'(dq_valid), 32'h1);
    rst         = 1'b1;
    imem_resp   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h1eceb300;
    tick();
    chk("midrst_rmask", 32'(imem_rmask), 32'h0);
    chk("midrst_addr", imem_addr, RPC);
    chk("midrst_valid", 32'(dq_valid), 32'h0);
    rst       = 1'b0;
    imem_resp = 1'b0;
    redirect  = 1'b0;
    tick();
    chk("refetch_rmask", 32'(imem_rmask), 32'hF);
    chk("refetch_addr", imem_addr, RPC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
